// File: rtl/control_pkg.sv
// Shared types and encodings for the LEGv8 multicycle sequencer.
// Opcode constants are the 11-bit instruction[31:21] field.
package control_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR,
    S_MEM_RD, S_WB_LD, S_MEM_WR, S_BRANCH, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_LOAD, CLS_STORE, CLS_CBZ, CLS_HLT, CLS_ILLEGAL
  } op_class_t;

  localparam logic [10:0] OP_ADD      = 11'b10001011000;
  localparam logic [10:0] OP_SUB      = 11'b11001011000;
  localparam logic [10:0] OP_AND      = 11'b10001010000;
  localparam logic [10:0] OP_ORR      = 11'b10101010000;
  localparam logic [10:0] OP_LDUR     = 11'b11111000010;
  localparam logic [10:0] OP_STUR     = 11'b11111000000;
  localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;
  localparam logic [10:0] OP_CBZ_VAL  = 11'b10110100000;
  localparam logic [10:0] OP_HLT      = 11'b11010100010;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational map from instruction[31:21] to an instruction class.
// Zero latency; no flow control.
module opcode_classifier
  import control_pkg::*;
(
  input  logic [10:0] i_opcode,
  output op_class_t   o_class
);

  always_comb begin
    o_class = CLS_ILLEGAL;
    if (i_opcode inside {OP_ADD, OP_SUB, OP_AND, OP_ORR})
      o_class = CLS_R;
    else if (i_opcode == OP_LDUR)
      o_class = CLS_LOAD;
    else if (i_opcode == OP_STUR)
      o_class = CLS_STORE;
    else if ((i_opcode & OP_CBZ_MASK) == OP_CBZ_VAL)
      o_class = CLS_CBZ;
    else if (i_opcode == OP_HLT)
      o_class = CLS_HLT;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencer: Moore decode of the registered state, plus the
// shared memory-port handshake (states hold until mem_ack).
module multicycle_control
  import control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_to_loc,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  logic             r_halted;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  op_class_t        w_class;
  logic             w_unused_zero;

  // The branch decision is taken in the datapath from pc_write_cond & zero.
  assign w_unused_zero = zero;

  opcode_classifier u_classifier (
    .i_opcode (opcode),
    .o_class  (w_class)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (run) r_state <= S_FETCH;
        S_FETCH:  if (mem_ack) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_class)
            CLS_R:               r_state <= S_EXEC_R;
            CLS_LOAD, CLS_STORE: r_state <= S_ADDR;
            CLS_CBZ:             r_state <= S_BRANCH;
            CLS_HLT: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            default: begin
              r_state   <= S_HALT;
              r_halted  <= 1'b1;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_EXEC_R: r_state <= S_WB_R;
        S_ADDR:   r_state <= (w_class == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: if (mem_ack) r_state <= S_WB_LD;
        S_MEM_WR: begin
          if (mem_ack) begin
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= run ? S_FETCH : S_IDLE;
          end
        end
        // Final states of R-type, LDUR and CBZ retire unconditionally.
        S_WB_R, S_WB_LD, S_BRANCH: begin
          r_retired <= r_retired + CNT_W'(1);
          r_state   <= run ? S_FETCH : S_IDLE;
        end
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    reg_to_loc    = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_SEXT_SH2;
        reg_to_loc = (w_class == CLS_STORE) || (w_class == CLS_CBZ);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_WB_R:   reg_write = 1'b1;
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        reg_to_loc = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        reg_to_loc    = 1'b1;
        alu_op        = ALU_PASS_B;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted  = r_halted;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle strobe vectors and counters
// are checked against hand-computed values.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src;
  logic        alu_src_a, reg_to_loc, reg_write, mem_to_reg, halted, illegal;
  logic [1:0]  alu_src_b, alu_op;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_to_loc(reg_to_loc), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
  //  alu_src_a, alu_src_b[1:0], alu_op[1:0], reg_to_loc, reg_write,
  //  mem_to_reg, halted, illegal}
  logic [16:0] w_outs;
  assign w_outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                   pc_src, alu_src_a, alu_src_b, alu_op, reg_to_loc,
                   reg_write, mem_to_reg, halted, illegal};

  localparam logic [16:0] V_IDLE     = 17'b0_0_0_0_0_0_0_0_00_00_0_0_0_0_0;
  localparam logic [16:0] V_FETCH_W  = 17'b1_0_0_0_0_0_0_0_01_00_0_0_0_0_0;
  localparam logic [16:0] V_FETCH_A  = 17'b1_0_0_1_1_0_0_0_01_00_0_0_0_0_0;
  localparam logic [16:0] V_DEC      = 17'b0_0_0_0_0_0_0_0_11_00_0_0_0_0_0;
  localparam logic [16:0] V_DEC_RL   = 17'b0_0_0_0_0_0_0_0_11_00_1_0_0_0_0;
  localparam logic [16:0] V_EXEC     = 17'b0_0_0_0_0_0_0_1_00_10_0_0_0_0_0;
  localparam logic [16:0] V_WB_R     = 17'b0_0_0_0_0_0_0_0_00_00_0_1_0_0_0;
  localparam logic [16:0] V_ADDR     = 17'b0_0_0_0_0_0_0_1_10_00_0_0_0_0_0;
  localparam logic [16:0] V_MEM_RD   = 17'b1_0_1_0_0_0_0_0_00_00_0_0_0_0_0;
  localparam logic [16:0] V_WB_LD    = 17'b0_0_0_0_0_0_0_0_00_00_0_1_1_0_0;
  localparam logic [16:0] V_MEM_WR   = 17'b1_1_1_0_0_0_0_0_00_00_1_0_0_0_0;
  localparam logic [16:0] V_BRANCH   = 17'b0_0_0_0_0_1_1_1_00_01_1_0_0_0_0;
  localparam logic [16:0] V_HALT     = 17'b0_0_0_0_0_0_0_0_00_00_0_0_0_1_0;
  localparam logic [16:0] V_HALT_ILL = 17'b0_0_0_0_0_0_0_0_00_00_0_0_0_1_1;

  localparam logic [10:0] C_ADD  = 11'b10001011000;
  localparam logic [10:0] C_SUB  = 11'b11001011000;
  localparam logic [10:0] C_LDUR = 11'b11111000010;
  localparam logic [10:0] C_STUR = 11'b11111000000;
  localparam logic [10:0] C_CBZ  = 11'b10110100101;
  localparam logic [10:0] C_HLT  = 11'b11010100010;

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; opcode = '0; zero = 1'b0; mem_ack = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if (w_outs !== V_IDLE) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", w_outs, V_IDLE);
    end
    n_checks++;
    if (retired !== 32'd0) begin
      n_fail++; $display("FAIL reset_retired: got %0d want 0", retired);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    logic [17:0] rows [4] = '{{1'b1, V_FETCH_A}, {1'b0, V_DEC},
                              {1'b0, V_EXEC}, {1'b0, V_WB_R}};
    @(negedge clk);
    run = 1'b1; opcode = C_ADD; mem_ack = 1'b0; #1;
    n_checks++;
    if (w_outs !== V_IDLE) begin
      n_fail++; $display("FAIL add_idle: got %b want %b", w_outs, V_IDLE);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack = rows[i][17]; #1;
      n_checks++;
      if (w_outs !== rows[i][16:0]) begin
        n_fail++; $display("FAIL add_cycle%0d: got %b want %b", i, w_outs, rows[i][16:0]);
      end
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    n_checks++;
    if (retired !== 32'd1 || w_outs !== V_FETCH_W) begin
      n_fail++; $display("FAIL add_retire: got %0d/%b want 1/%b", retired, w_outs, V_FETCH_W);
    end
  endtask

  task automatic test_ldur_wait();
    logic [17:0] rows [8] = '{{1'b1, V_FETCH_A}, {1'b0, V_DEC}, {1'b0, V_ADDR},
                              {1'b0, V_MEM_RD}, {1'b0, V_MEM_RD}, {1'b0, V_MEM_RD},
                              {1'b1, V_MEM_RD}, {1'b0, V_WB_LD}};
    opcode = C_LDUR;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); mem_ack = rows[i][17]; #1;
      n_checks++;
      if (w_outs !== rows[i][16:0]) begin
        n_fail++; $display("FAIL ldur_cycle%0d: got %b want %b", i, w_outs, rows[i][16:0]);
      end
    end
    @(negedge clk); mem_ack = 1'b0; #1;
    n_checks++;
    if (retired !== 32'd2 || w_outs !== V_FETCH_W) begin
      n_fail++; $display("FAIL ldur_retire: got %0d/%b want 2/%b", retired, w_outs, V_FETCH_W);
    end
  endtask

  task automatic test_cbz();
    logic [17:0] rows [3] = '{{1'b1, V_FETCH_A}, {1'b0, V_DEC_RL}, {1'b0, V_BRANCH}};
    opcode = C_CBZ;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); mem_ack = rows[i][17]; #1;
        n_checks++;
        if (w_outs !== rows[i][16:0]) begin
          n_fail++; $display("FAIL cbz%0d_cycle%0d: got %b want %b", k, i, w_outs, rows[i][16:0]);
        end
      end
      @(negedge clk); mem_ack = 1'b0; #1;
      n_checks++;
      if (retired !== 32'(3 + k) || w_outs !== V_FETCH_W) begin
        n_fail++; $display("FAIL cbz%0d_retire: got %0d/%b want %0d/%b", k, retired, w_outs, 3 + k, V_FETCH_W);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_run_drop();
    logic [17:0] rows [4] = '{{1'b1, V_FETCH_A}, {1'b0, V_DEC},
                              {1'b0, V_EXEC}, {1'b0, V_WB_R}};
    opcode = C_SUB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ack = rows[i][17];
      if (i == 2) run = 1'b0;
      #1;
      n_checks++;
      if (w_outs !== rows[i][16:0]) begin
        n_fail++; $display("FAIL rundrop_cycle%0d: got %b want %b", i, w_outs, rows[i][16:0]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ack = 1'b0; #1;
      n_checks++;
      if (w_outs !== V_IDLE || retired !== 32'd5) begin
        n_fail++; $display("FAIL rundrop_idle%0d: got %b/%0d want %b/5", i, w_outs, retired, V_IDLE);
      end
    end
    @(negedge clk); run = 1'b1; #1;
    n_checks++;
    if (w_outs !== V_IDLE) begin
      n_fail++; $display("FAIL rundrop_rise: got %b want %b", w_outs, V_IDLE);
    end
    @(negedge clk); #1;
    n_checks++;
    if (w_outs !== V_FETCH_W) begin
      n_fail++; $display("FAIL rundrop_resume: got %b want %b", w_outs, V_FETCH_W);
    end
  endtask

  task automatic test_stur_reset();
    logic [17:0] rows [5] = '{{1'b1, V_FETCH_A}, {1'b0, V_DEC_RL}, {1'b0, V_ADDR},
                              {1'b0, V_MEM_WR}, {1'b0, V_MEM_WR}};
    opcode = C_STUR;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ack = rows[i][17]; #1;
      n_checks++;
      if (w_outs !== rows[i][16:0]) begin
        n_fail++; $display("FAIL stur_cycle%0d: got %b want %b", i, w_outs, rows[i][16:0]);
      end
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || w_outs !== V_IDLE || retired !== 32'd0) begin
      n_fail++; $display("FAIL stur_async_reset: got req=%b we=%b outs=%b ret=%0d want 0 0 %b 0",
                         mem_req, mem_we, w_outs, retired, V_IDLE);
    end
    run = 1'b0;
    #1 reset_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (w_outs !== V_IDLE || retired !== 32'd0) begin
      n_fail++; $display("FAIL stur_post_reset: got %b/%0d want %b/0", w_outs, retired, V_IDLE);
    end
  endtask

  task automatic test_illegal();
    logic [17:0] rows [2] = '{{1'b1, V_FETCH_A}, {1'b0, V_DEC}};
    @(negedge clk); run = 1'b1; opcode = 11'h000; #1;
    n_checks++;
    if (w_outs !== V_IDLE) begin
      n_fail++; $display("FAIL illegal_idle: got %b want %b", w_outs, V_IDLE);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ack = rows[i][17]; #1;
      n_checks++;
      if (w_outs !== rows[i][16:0]) begin
        n_fail++; $display("FAIL illegal_cycle%0d: got %b want %b", i, w_outs, rows[i][16:0]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); mem_ack = i[0]; #1;
      n_checks++;
      if (w_outs !== V_HALT_ILL || retired !== 32'd0) begin
        n_fail++; $display("FAIL illegal_halt%0d: got %b/%0d want %b/0", i, w_outs, retired, V_HALT_ILL);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_hlt();
    logic [17:0] rows [9] = '{{1'b1, V_FETCH_A}, {1'b0, V_DEC}, {1'b0, V_EXEC},
                              {1'b0, V_WB_R}, {1'b1, V_FETCH_A}, {1'b0, V_DEC},
                              {1'b0, V_HALT}, {1'b0, V_HALT}, {1'b0, V_HALT}};
    @(negedge clk); reset_n = 1'b0; run = 1'b0; #1 reset_n = 1'b1;
    @(negedge clk); run = 1'b1; opcode = C_ADD; #1;
    n_checks++;
    if (w_outs !== V_IDLE) begin
      n_fail++; $display("FAIL hlt_idle: got %b want %b", w_outs, V_IDLE);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); mem_ack = rows[i][17];
      if (i == 4) opcode = C_HLT;
      #1;
      n_checks++;
      if (w_outs !== rows[i][16:0]) begin
        n_fail++; $display("FAIL hlt_cycle%0d: got %b want %b", i, w_outs, rows[i][16:0]);
      end
    end
    n_checks++;
    if (retired !== 32'd1) begin
      n_fail++; $display("FAIL hlt_retired: got %0d want 1", retired);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldur_wait();
    test_cbz();
    test_run_drop();
    test_stur_reset();
    test_illegal();
    test_hlt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the LEGv8 datapath. It replaces the single-cycle combinational control unit: the PC, instruction register, register bank, ALU and one unified memory port are reused across several cycles per instruction. The FSM decodes `instruction[31:21]` and drives every datapath select and write-enable. It also owns the memory request/acknowledge handshake for both instruction fetch and data access, which shares the single memory port between the two.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; allows leaving IDLE to fetch
- opcode  in  11  instruction register bits [31:21]
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (STUR), 0 = read
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero=1 (CBZ)
- pc_src  out  1  0 = ALU result, 1 = ALUOut register
- alu_src_a  out  1  0 = PC, 1 = reg_data_1
- alu_src_b  out  2  00 reg_data_2, 01 constant 4, 10 sign-extend, 11 sign-extend<<2
- alu_op  out  2  00 add, 01 pass B, 10 funct-decoded (AluControl)
- reg_to_loc  out  1  read-register-2 select
- reg_write  out  1  register bank write enable
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = memory data register
- halted  out  1  sticky; HLT or illegal opcode seen
- illegal  out  1  sticky; halt was caused by an unknown opcode
- retired  out  CNT_W  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LD, MEM_WR, BRANCH, HALT.
- IDLE: all strobes 0. Moves to FETCH when run=1.
- FETCH: mem_req=1, iord=0, mem_we=0, alu_src_a=0, alu_src_b=01, alu_op=00. The state holds until mem_ack. In the ack cycle ir_write=1 and pc_write=1 (pc_src=0); next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). reg_to_loc=1 for STUR/CBZ, 0 otherwise. Dispatch by opcode:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000) → EXEC_R
  - LDUR 11111000010 or STUR 11111000000 → ADDR
  - CBZ 10110100xxx → BRANCH
  - HLT 11010100010 → HALT
  - anything else → HALT with illegal=1
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next state WB_R.
- WB_R: reg_write=1, mem_to_reg=0; next state FETCH, or IDLE if run=0.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: mem_req=1, iord=1, mem_we=0, held until mem_ack; next state WB_LD.
- WB_LD: reg_write=1, mem_to_reg=1.
- MEM_WR: mem_req=1, iord=1, mem_we=1, reg_to_loc=1, held until mem_ack. This is the last state of STUR.
- BRANCH: alu_src_a=1, alu_src_b=00, reg_to_loc=1, alu_op=01, pc_write_cond=1, pc_src=1. This is the last state of CBZ.
- Leaving any last state: retired increments by 1, with 2^CNT_W wrap-around. Next state is FETCH if run=1, else IDLE.
- HALT: all strobes 0, halted=1. Only reset exits HALT. HLT is not counted as retired.

## Timing
- Reset: state=IDLE, every output 0, retired=0. Applies immediately when asserted, including mid-request; mem_req drops the same instant.
- Handshake:
  - mem_req, mem_we and iord are stable from assertion until the ack cycle.
  - An ack in the first request cycle is legal (zero-wait).
  - mem_ack while mem_req=0 is ignored.
- Cycles per instruction with zero-wait memory (extra memory wait cycles add 1 each):
  - R-type: 4
  - LDUR: 5
  - STUR: 4
  - CBZ: 3
- run falling mid-instruction: the current instruction completes, then the FSM enters IDLE. run rising in IDLE: FETCH begins on the next cycle.
- Only one memory request is ever outstanding. Fetch and data accesses never overlap.

## Structure
- Package control_pkg holds:
  - state enum
  - 11-bit opcode constants (ADD, SUB, AND, ORR, LDUR, STUR, CBZ mask/value, HLT)
  - alu_op and alu_src_b encodings
- Sub-module opcode_classifier (combinational) maps opcode to a class enum: R, LOAD, STORE, CBZ, HLT, ILLEGAL.
- The FSM and output decode live in multicycle_control, with registered state and Moore outputs. The only exceptions are ir_write and pc_write in FETCH, which are gated by mem_ack.

## Test plan
- Reset, then run=1, then ADD with zero-wait ack → FETCH, DECODE, EXEC_R, WB_R. reg_write is high only in cycle 4, and retired=1.
- LDUR with mem_ack delayed 3 cycles in MEM_RD → mem_req/iord=1 held for 4 cycles. WB_LD follows with mem_to_reg=1, and the instruction totals 8 cycles.
- CBZ with zero=1, then zero=0 → pc_write_cond=1 in BRANCH both times, with pc_src=1 and alu_op=01. Each takes 3 cycles.
- Opcode 0x000 → HALT with halted=1, illegal=1, and all strobes 0 for 10+ cycles. HLT opcode gives halted=1, illegal=0, and retired unchanged.
- reset_n pulsed low during a MEM_WR wait → mem_req and mem_we drop asynchronously. After release the FSM is in IDLE with retired=0.
- run dropped during EXEC_R → WB_R completes, then the FSM enters IDLE with no further mem_req. Raising run resumes in FETCH the next cycle.
